// File: rtl/tt_uart_tx_fifo.sv
// tt_uart_tx_fifo: small byte FIFO feeding an LSB-first UART transmitter.
// Default frame is 8N1. Defining UART_TX_PARITY_EN inserts an even parity bit
// between the last data bit and the stop bit (8E1).
// All outputs are registered; tx idles high.
module tt_uart_tx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 87,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [7:0]                  wr_data,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

   localparam logic [CntW-1:0]  CountFull = CntW'(FIFO_DEPTH);
   localparam logic [BaudW-1:0] BaudLast  = BaudW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [CntW-1:0]  count_q;

   state_e           state_q;
   logic [BaudW-1:0] baud_q;
   logic [2:0]       bit_q;
   logic [7:0]       shift_q;
   logic             tx_q;
   logic             busy_q;
`ifdef UART_TX_PARITY_EN
   logic             parity_q;
`endif

   logic push;
   logic pop;

   // Ready depends only on the registered count, so a same-cycle pop never frees a full FIFO.
   assign wr_ready = (count_q < CountFull);
   assign push     = wr_valid & wr_ready;
   assign pop      = (state_q == StIdle) && (count_q != '0);

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign fifo_count = count_q;

   // FIFO storage; stale entries are harmless because reset clears the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   // FIFO pointers and occupancy count; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Transmit FSM; tx and busy are registered from the current state, so they trail it by
   // one cycle and every bit on the line lasts exactly CLKS_PER_BIT cycles.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         busy_q <= (state_q != StIdle) || (count_q != '0);
         unique case (state_q)
            StIdle: begin
               tx_q <= 1'b1;
               if (pop) begin
                  shift_q  <= mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                  parity_q <= ^mem_q[rd_ptr_q];
`endif
                  baud_q   <= BaudLast;
                  state_q  <= StStart;
               end
            end
            StStart: begin
               tx_q <= 1'b0;
               if (baud_q == '0) begin
                  baud_q  <= BaudLast;
                  bit_q   <= '0;
                  state_q <= StData;
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
            StData: begin
               tx_q <= shift_q[0];
               if (baud_q == '0) begin
                  baud_q  <= BaudLast;
                  shift_q <= {1'b0, shift_q[7:1]};
                  if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state_q <= StParity;
`else
                     state_q <= StStop;
`endif
                  end else begin
                     bit_q <= bit_q + 3'd1;
                  end
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
               tx_q <= parity_q;
               if (baud_q == '0) begin
                  baud_q  <= BaudLast;
                  state_q <= StStop;
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
`endif
            StStop: begin
               tx_q <= 1'b1;
               if (baud_q == '0) begin
                  state_q <= StIdle;
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
            default: begin
               tx_q    <= 1'b1;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tt_uart_tx_fifo.sv
// tb_tt_uart_tx_fifo: self-checking bench for tt_uart_tx_fifo (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A UART receiver model decodes tx and compares each frame against a scoreboard queue.
// Define UART_TX_PARITY_EN for both bench and design to cover the parity build.
module tb_tt_uart_tx_fifo;

   localparam int unsigned CPB   = 4;
   localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int Spacing = NB * CPB + 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] sb[$];
   int         starts[$];
   logic       par_log[$];
   bit         mon_active = 1'b0;
   bit         rst_seen = 1'b0;
   logic       tx_prev = 1'b0;

   tt_uart_tx_fifo #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_data   (wr_data),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .tx        (tx),
      .busy      (busy),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rst_n === 1'b0) rst_seen = 1'b1;
   end

   // Receiver model: detect the start edge, sample mid-bit, compare against the scoreboard.
   always begin
      logic [7:0] data;
      logic [7:0] exp;
      logic       start_ok;
      logic       par;
      logic       stop;
      @(negedge clk);
      if (rst_n === 1'b1 && tx_prev === 1'b1 && tx === 1'b0) begin
         mon_active = 1'b1;
         rst_seen   = 1'b0;
         starts.push_back(cyc);
         repeat (CPB / 2) @(negedge clk);
         start_ok = (tx === 1'b0);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            data[i] = tx;
         end
         par = 1'b0;
`ifdef UART_TX_PARITY_EN
         repeat (CPB) @(negedge clk);
         par = tx;
`endif
         repeat (CPB) @(negedge clk);
         stop = tx;
         if (!rst_seen) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL frame_unexpected: got byte %02h, scoreboard empty", data);
            end else begin
               exp = sb.pop_front();
               if (start_ok !== 1'b1 || stop !== 1'b1 || data !== exp) begin
                  errors++;
                  $display("FAIL frame: got byte %02h start_ok %b stop %b, expected byte %02h",
                           data, start_ok, stop, exp);
               end
`ifdef UART_TX_PARITY_EN
               checks++;
               if (par !== ^exp) begin
                  errors++;
                  $display("FAIL frame_parity: got %b expected %b for %02h", par, ^exp, exp);
               end
`endif
               par_log.push_back(par);
            end
         end
         tx_prev    = tx;
         mon_active = 1'b0;
      end else begin
         tx_prev = tx;
      end
   end

   task automatic wait_done();
      int n = 0;
      while ((busy !== 1'b0 || mon_active || fifo_count !== 3'd0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL wait_done: still busy after %0d cycles, expected idle", n);
      end
   endtask

   task automatic test_reset();
      int bad = 0;
      rst_n    = 1'b0;
      wr_valid = 1'b1;
      wr_data  = 8'hFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++;
      if (wr_ready !== 1'b1) begin
         errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready);
      end
      checks++;
      if (fifo_count !== 3'd0) begin
         errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count);
      end
      wr_valid = 1'b0;
      rst_n    = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (fifo_count !== 3'd0 || tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL reset_no_enqueue: got %0d bad cycles (count %0d tx %b), expected 0",
                  bad, fifo_count, tx);
      end
   endtask

   task automatic test_single();
      logic [7:0] d = 8'hA5;
      logic       bits [NB];
      int         bad;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i + 1] = d[i];
`ifdef UART_TX_PARITY_EN
      bits[9] = ^d;
`endif
      bits[NB - 1] = 1'b1;
      wait_done();
      @(negedge clk);
      wr_data  = d;
      wr_valid = 1'b1;
      sb.push_back(d);
      @(negedge clk);
      wr_valid = 1'b0;
      checks++;
      if (tx !== 1'b1 || fifo_count !== 3'd1) begin
         errors++;
         $display("FAIL single_edge1: got tx %b count %0d, expected tx 1 count 1", tx, fifo_count);
      end
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_pop: got tx %b count %0d busy %b, expected 1 0 1",
                  tx, fifo_count, busy);
      end
      @(negedge clk);
      for (int b = 0; b < NB; b++) begin
         bad = 0;
         for (int c = 0; c < int'(CPB); c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (tx !== bits[b]) bad++;
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL single_bit%0d: got %0d wrong cycles (tx %b), expected %b",
                     b, bad, tx, bits[b]);
         end
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL single_busy_stop: got %b expected 1", busy);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL single_busy_drop: got busy %b tx %b, expected 0 1", busy, tx);
      end
      wait_done();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL single_sb: got %0d left expected 0", sb.size());
      end
   endtask

   task automatic test_fill();
      int n;
      wait_done();
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         checks++;
         if (wr_ready !== 1'b1) begin
            errors++; $display("FAIL fill_accept%0d: got wr_ready %b expected 1", i, wr_ready);
         end
         if (i == 3) begin
            checks++;
            if (fifo_count !== 3'd1) begin
               errors++; $display("FAIL fill_first_pop: got count %0d expected 1", fifo_count);
            end
         end
         wr_data  = 8'(i);
         wr_valid = 1'b1;
         sb.push_back(8'(i));
      end
      @(negedge clk);
      checks++;
      if (wr_ready !== 1'b0 || fifo_count !== 3'd4) begin
         errors++;
         $display("FAIL fill_full: got wr_ready %b count %0d, expected 0 4", wr_ready, fifo_count);
      end
      wr_data = 8'h06;
      n = 5;
      while (wr_ready !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != Spacing + 2) begin
         errors++;
         $display("FAIL fill_unblock: got ready at cycle %0d expected %0d", n, Spacing + 2);
      end
      sb.push_back(8'h06);
      @(negedge clk);
      wr_valid = 1'b0;
      wait_done();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL fill_sb: got %0d left expected 0", sb.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] vals [3] = '{8'h5A, 8'hC3, 8'h0F};
      wait_done();
      starts.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         wr_data  = vals[i];
         wr_valid = 1'b1;
         sb.push_back(vals[i]);
      end
      @(negedge clk);
      wr_valid = 1'b0;
      wait_done();
      checks++;
      if (starts.size() != 3) begin
         errors++; $display("FAIL b2b_frames: got %0d frames expected 3", starts.size());
      end else begin
         for (int i = 1; i < 3; i++) begin
            checks++;
            if (starts[i] - starts[i - 1] != Spacing) begin
               errors++;
               $display("FAIL b2b_spacing%0d: got %0d cycles expected %0d",
                        i, starts[i] - starts[i - 1], Spacing);
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL b2b_sb: got %0d left expected 0", sb.size());
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      int bad = 0;
      wait_done();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         wr_data  = 8'h11 * 8'(i + 1);
         wr_valid = 1'b1;
      end
      @(negedge clk);
      wr_valid = 1'b0;
      while (tx !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 50) begin errors++; $display("FAIL mid_start: got no start bit, expected one"); end
      repeat (4 * CPB + 1) @(negedge clk);
      checks++;
      if (fifo_count !== 3'd2) begin
         errors++; $display("FAIL mid_queued: got count %0d expected 2", fifo_count);
      end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: got tx %b count %0d busy %b ready %b, expected 1 0 0 1",
                  tx, fifo_count, busy, wr_ready);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL mid_flushed: got %0d active cycles expected 0", bad);
      end
      @(negedge clk);
      wr_data  = 8'h3C;
      wr_valid = 1'b1;
      sb.push_back(8'h3C);
      @(negedge clk);
      wr_valid = 1'b0;
      wait_done();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL mid_sb: got %0d left expected 0", sb.size());
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      wait_done();
      starts.delete();
      par_log.delete();
      @(negedge clk);
      wr_data  = 8'h07;
      wr_valid = 1'b1;
      sb.push_back(8'h07);
      @(negedge clk);
      wr_data = 8'h03;
      sb.push_back(8'h03);
      @(negedge clk);
      wr_valid = 1'b0;
      wait_done();
      checks++;
      if (par_log.size() != 2 || starts.size() != 2) begin
         errors++;
         $display("FAIL parity_frames: got %0d/%0d frames expected 2", par_log.size(),
                  starts.size());
      end else begin
         checks++;
         if (par_log[0] !== 1'b1 || par_log[1] !== 1'b0) begin
            errors++;
            $display("FAIL parity_bits: got %b %b expected 1 0", par_log[0], par_log[1]);
         end
         checks++;
         if (starts[1] - starts[0] != 45) begin
            errors++;
            $display("FAIL parity_spacing: got %0d expected 45", starts[1] - starts[0]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_back_to_back();
      test_reset_mid();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/tt_uart_tx_fifo.md
Name: tt_uart_tx_fifo

Overview:
- Serial output stage instantiated inside the Tiny Tapeout top wrapper, directly downstream of the dedicated inputs.
- Accepts bytes through a valid/ready write port and buffers them in a small FIFO.
- Transmits them LSB-first as 8N1 UART frames on one dedicated output pin; the top wrapper drives uo_out[0] from it.
- Status outputs go to the remaining uo_out bits for debug.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit (87 = 10 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- wr_data  input  8  byte to enqueue.
- wr_valid  input  1  producer offers wr_data this cycle.
- wr_ready  output  1  FIFO can accept; high when fifo_count < FIFO_DEPTH.
- tx  output  1  UART line; idle high.
- busy  output  1  high while (state != IDLE) or (fifo_count != 0).
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes stored, excluding the one being shifted.

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-low, sampled on the rising clk edge. While rst_n=0 at an edge, the block sets:
  - tx=1, busy=0, wr_ready=1, fifo_count=0
  - state=IDLE, read and write pointers 0, bit and baud counters 0.
- Reset mid-frame: the frame aborts and the FIFO is flushed. tx is high after the first reset edge.
- Write handshake: wr_valid & wr_ready at an edge stores wr_data at the write pointer. Pointers wrap modulo FIFO_DEPTH.
- wr_ready is decoded from the registered count only. When full, it stays low even if a pop occurs in the same cycle; there is no combinational path from the pop to ready.
- Writing while full (wr_valid=1, wr_ready=0) is ignored; no data is corrupted.
- Simultaneous push and pop when not full: fifo_count is unchanged and both pointers advance.
- State machine: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count>0 at an edge, pop the head into an 8-bit shift register, decrement the count, go to START and load the baud counter.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with the bit index at 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency: a byte written at edge N into an empty, idle FIFO is popped at edge N+1. tx falls at edge N+2, because tx is registered.
- Back-to-back frames: IDLE lasts exactly 1 cycle between frames. Consecutive start-bit falling edges are 10*CLKS_PER_BIT+1 cycles apart.
- Baud counter: counts CLKS_PER_BIT-1 down to 0; width $clog2(CLKS_PER_BIT). A terminal count of 0 advances the bit or state.
- All outputs are registered. tx is glitch-free.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame spacing becomes 11*CLKS_PER_BIT+1.
- Undefined: 8N1 exactly as above, and no parity logic is synthesized.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with wr_valid=1 -> tx=1, busy=0, wr_ready=1, fifo_count=0; nothing is enqueued.
- Single byte 0xA5, CLKS_PER_BIT=4:
  - tx falls 2 edges after the handshake.
  - Line pattern 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - busy drops after the stop bit completes.
- Fill, FIFO_DEPTH=4:
  - Write 0x01..0x05 on consecutive cycles -> 0x01 is popped at once, 0x02..0x05 are accepted.
  - A 6th write is blocked by wr_ready=0 until the first pop after the 0x01 frame.
  - Output order is 0x01..0x05 with no loss or duplication.
- Back-to-back: 3 bytes queued -> falling start edges are exactly 41 cycles apart (CLKS_PER_BIT=4).
- Reset mid-frame: assert rst_n=0 during DATA bit 3 with 2 bytes queued -> tx=1 after the first edge and fifo_count=0. A new byte 0x3C after reset transmits correctly.
- UART_TX_PARITY_EN: send 0x07 -> parity bit 1; send 0x03 -> parity bit 0. Frame spacing is 45 cycles at CLKS_PER_BIT=4.
